sys_ctrl_fsm: RTL and testbench
===============================

// Module: sys_ctrl_fsm
// PURPOSE
// Command sequencer between the UART RX/TX pair and the register file and ALU. Parses byte
// commands from RX: RF write, RF read, ALU op with new operands, ALU op on stored operands.
// Drives RF/ALU strobes and returns results to TX: one byte for a read, two bytes (LSB first)
// for an ALU result. Runs entirely in the REF_CLK domain; RX inputs arrive already synchronised.
// PARAMETERS
// DATA_W    8      byte width of RX/TX/RF data
// ADDR_W    4      RF address width
// FUN_W     4      ALU function code width
// WR_CMD    8'hAA  RF write: {CMD, ADDR, DATA}
// RD_CMD    8'hBB  RF read: {CMD, ADDR}
// ALU_CMD   8'hCC  ALU op with operands: {CMD, OPA, OPB, FUN}
// NOP_CMD   8'hDD  ALU op on stored operands: {CMD, FUN}
// OPA_ADDR  0      RF address of operand A; OPB_ADDR 1 = RF address of operand B
// WAIT_MAX  15     max cycles waiting for RF/ALU valid before abort
// PORTS
// REF_CLK        in   1         system clock
// RST            in   1         asynchronous reset, active-high
// RX_P_DATA      in   DATA_W    received byte
// RX_D_VLD       in   1         one-cycle pulse, RX_P_DATA valid
// RF_RD_DATA     in   DATA_W    RF read data; RF_RD_DATA_VLD in 1 = read data valid pulse
// ALU_OUT        in   2*DATA_W  ALU result; ALU_OUT_VLD in 1 = result valid pulse
// TX_BUSY        in   1         TX serialising a byte
// RF_ADDR        out  ADDR_W    RF address
// RF_WR_EN       out  1         one-cycle RF write strobe
// RF_RD_EN       out  1         one-cycle RF read strobe
// RF_WR_DATA     out  DATA_W    RF write data
// ALU_EN         out  1         ALU enable
// ALU_FUN        out  FUN_W     ALU function code
// CLK_GATE_EN    out  1         ALU clock-gate enable
// TX_P_DATA      out  DATA_W    byte to transmit; TX_D_VLD out 1 = TX request
// ERR_PULSE      out  1         one-cycle pulse: timeout abort or byte dropped
// BEHAVIOUR
// - Reset: state IDLE; every output 0; internal byte/result registers 0; wait counter 0.
// - States: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OPA, OPB, FUN, ALU_WAIT,
//   TX0, TX0_WAIT, TX1, TX1_WAIT. Transitions on RX_D_VLD unless stated.
// - IDLE: byte==WR_CMD->WR_ADDR, RD_CMD->RD_ADDR, ALU_CMD->OPA, NOP_CMD->FUN; other bytes ignored, no ERR.
// - WR_ADDR latches byte[ADDR_W-1:0]; WR_DATA: next cycle RF_WR_EN=1 for 1 cycle, RF_ADDR=latched
//   addr, RF_WR_DATA=byte; ->IDLE.
// - RD_ADDR: next cycle RF_RD_EN=1 for 1 cycle; ->RD_WAIT; on RF_RD_DATA_VLD latch data ->TX1
//   (single byte).
// - OPA/OPB: write byte to OPA_ADDR/OPB_ADDR as a WR_DATA write; OPA->OPB->FUN.
// - FUN: latch byte[FUN_W-1:0] to ALU_FUN; ->ALU_WAIT with ALU_EN=CLK_GATE_EN=1; both held until
//   ALU_OUT_VLD, cleared the cycle after; ALU_OUT latched ->TX0.
// - RD_WAIT/ALU_WAIT: counter increments per cycle; reaching WAIT_MAX without valid -> ERR_PULSE,
//   strobes/enables cleared, ->IDLE. Counter clears on entry.
// - TX handshake: TXn drives TX_P_DATA, TX_D_VLD=1 while TX_BUSY=0; on TX_BUSY=1 drop TX_D_VLD
//   ->TXn_WAIT; on TX_BUSY=0 ->next. TX0 sends result[7:0], TX1 sends result[15:8] or read byte;
//   TX1_WAIT ->IDLE. If TX_BUSY already 1 on entry, TX_D_VLD stays 0 until it falls.
// - RX_D_VLD in any state not consuming a byte (RD_WAIT, ALU_WAIT, TX*): byte dropped, ERR_PULSE.
// - Valid pulse coincident with timeout cycle: valid wins, no ERR.
// - RST mid-command: immediate return to IDLE, pending command discarded, outputs 0.
// STRUCTURE
// - Shared package: command codes, OPA/OPB addresses, state encoding enum, WAIT_MAX default.
// - One sub-module: sys_ctrl_tx_seq (TXn/TXn_WAIT handshake, 1- or 2-byte send, done pulse).
// - Main FSM: two-process (registered state, combinational next-state/outputs); strobes registered.
// TESTING
// - WR: AA,05,3C -> one RF_WR_EN cycle, RF_ADDR=5, RF_WR_DATA=3C; no TX, no ERR.
// - RD: BB,05; RF returns 3C after 2 cycles -> RF_RD_EN pulse, TX_P_DATA=3C, one TX_D_VLD burst.
// - ALU: CC,0A,14,00(add); ALU_OUT=001E -> writes addr0=0A, addr1=14, TX bytes 1E then 00.
// - NOP: DD,0A(shift right) with ALU_OUT=0005 -> no RF writes, TX 05 then 00; repeat with
//   shift-left FUN, ALU_OUT=0014 -> TX 14 then 00.
// - Timeout: BB,02 with no RF_RD_DATA_VLD -> ERR_PULSE after WAIT_MAX cycles, IDLE, next AA works.
// - Drop/reset: RX byte during TX1_WAIT -> ERR_PULSE, TX unaffected; RST during OPB -> all outputs 0,
//   next CC sequence completes normally.

Source files
------------

// File: rtl/sys_ctrl_fsm_pkg.sv
// Shared definitions for the UART command sequencer: command opcodes, operand
// addresses, the wait limit default and the state encoding.
package sys_ctrl_fsm_pkg;

    localparam logic [7:0] WrCmd  = 8'hAA;
    localparam logic [7:0] RdCmd  = 8'hBB;
    localparam logic [7:0] AluCmd = 8'hCC;
    localparam logic [7:0] NopCmd = 8'hDD;

    localparam logic [3:0] OpaAddr = 4'd0;
    localparam logic [3:0] OpbAddr = 4'd1;

    localparam int unsigned WaitMaxDef = 15;

    localparam int unsigned StateW = 4;
    typedef logic [StateW-1:0] state_t;

    localparam state_t StIdle    = 4'd0;
    localparam state_t StWrAddr  = 4'd1;
    localparam state_t StWrData  = 4'd2;
    localparam state_t StRdAddr  = 4'd3;
    localparam state_t StRdWait  = 4'd4;
    localparam state_t StOpa     = 4'd5;
    localparam state_t StOpb     = 4'd6;
    localparam state_t StFun     = 4'd7;
    localparam state_t StAluWait = 4'd8;
    localparam state_t StTx0     = 4'd9;
    localparam state_t StTx0Wait = 4'd10;
    localparam state_t StTx1     = 4'd11;
    localparam state_t StTx1Wait = 4'd12;

    // First state of a command given its opcode; unknown bytes keep the FSM idle.
    function automatic state_t cmd_state(input logic [7:0] cmd);
        state_t st;
        case (cmd)
            WrCmd:   st = StWrAddr;
            RdCmd:   st = StRdAddr;
            AluCmd:  st = StOpa;
            NopCmd:  st = StFun;
            default: st = StIdle;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/sys_ctrl_tx_seq.sv
// TX handshake sequencer: sends one byte (byte1) or two bytes (byte0 then byte1)
// to the UART transmitter and pulses done_o once the last byte has been taken.
module sys_ctrl_tx_seq
    import sys_ctrl_fsm_pkg::*;
#(
    parameter int unsigned DataW = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             two_byte_i,
    input  logic [DataW-1:0] byte0_i,
    input  logic [DataW-1:0] byte1_i,
    input  logic             tx_busy_i,
    output logic [DataW-1:0] tx_p_data_o,
    output logic             tx_d_vld_o,
    output logic             done_o
);

    state_t state_q, state_d;
    // Set once the current byte has been offered, so a transmitter that is still
    // busy from earlier traffic is not mistaken for having accepted it.
    logic   sent_q, sent_d;

    always_comb begin
        state_d     = state_q;
        sent_d      = sent_q;
        tx_p_data_o = '0;
        tx_d_vld_o  = 1'b0;
        done_o      = 1'b0;
        unique case (state_q)
            StIdle: begin
                sent_d = 1'b0;
                if (start_i) begin
                    state_d = two_byte_i ? StTx0 : StTx1;
                end
            end
            StTx0: begin
                tx_p_data_o = byte0_i;
                if (!tx_busy_i) begin
                    tx_d_vld_o = 1'b1;
                    sent_d     = 1'b1;
                end else if (sent_q) begin
                    sent_d  = 1'b0;
                    state_d = StTx0Wait;
                end
            end
            StTx0Wait: begin
                tx_p_data_o = byte0_i;
                if (!tx_busy_i) begin
                    state_d = StTx1;
                end
            end
            StTx1: begin
                tx_p_data_o = byte1_i;
                if (!tx_busy_i) begin
                    tx_d_vld_o = 1'b1;
                    sent_d     = 1'b1;
                end else if (sent_q) begin
                    sent_d  = 1'b0;
                    state_d = StTx1Wait;
                end
            end
            StTx1Wait: begin
                tx_p_data_o = byte1_i;
                if (!tx_busy_i) begin
                    done_o  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                sent_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            sent_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sent_q  <= sent_d;
        end
    end

endmodule

// File: rtl/sys_ctrl_fsm.sv
// Command sequencer between UART RX/TX and the register file / ALU: parses RX
// command bytes, issues registered RF/ALU strobes and returns results over TX.
module sys_ctrl_fsm
    import sys_ctrl_fsm_pkg::*;
#(
    parameter int unsigned DataW   = 8,
    parameter int unsigned AddrW   = 4,
    parameter int unsigned FunW    = 4,
    parameter int unsigned WaitMax = WaitMaxDef
) (
    input  logic               ref_clk_i,
    input  logic               rst_i,
    input  logic [DataW-1:0]   rx_p_data_i,
    input  logic               rx_d_vld_i,
    input  logic [DataW-1:0]   rf_rd_data_i,
    input  logic               rf_rd_data_vld_i,
    input  logic [2*DataW-1:0] alu_out_i,
    input  logic               alu_out_vld_i,
    input  logic               tx_busy_i,
    output logic [AddrW-1:0]   rf_addr_o,
    output logic               rf_wr_en_o,
    output logic               rf_rd_en_o,
    output logic [DataW-1:0]   rf_wr_data_o,
    output logic               alu_en_o,
    output logic [FunW-1:0]    alu_fun_o,
    output logic               clk_gate_en_o,
    output logic [DataW-1:0]   tx_p_data_o,
    output logic               tx_d_vld_o,
    output logic               err_pulse_o
);

    localparam int unsigned CntW = (WaitMax > 1) ? $clog2(WaitMax) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(WaitMax - 1);

    state_t             state_q, state_d;
    logic [AddrW-1:0]   addr_q, addr_d;
    logic [2*DataW-1:0] result_q, result_d;
    logic [CntW-1:0]    cnt_q, cnt_d;

    logic [AddrW-1:0]   rf_addr_q, rf_addr_d;
    logic               rf_wr_en_q, rf_wr_en_d;
    logic               rf_rd_en_q, rf_rd_en_d;
    logic [DataW-1:0]   rf_wr_data_q, rf_wr_data_d;
    logic               alu_en_q, alu_en_d;
    logic [FunW-1:0]    alu_fun_q, alu_fun_d;
    logic               gate_q, gate_d;
    logic               err_q, err_d;

    logic               tx_start;
    logic               tx_two;
    logic               tx_done;
    logic               wait_last;

    assign wait_last = (cnt_q == CntLast);

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        result_d     = result_q;
        cnt_d        = cnt_q;
        rf_addr_d    = rf_addr_q;
        rf_wr_en_d   = 1'b0;
        rf_rd_en_d   = 1'b0;
        rf_wr_data_d = rf_wr_data_q;
        alu_en_d     = alu_en_q;
        alu_fun_d    = alu_fun_q;
        gate_d       = gate_q;
        err_d        = 1'b0;
        tx_start     = 1'b0;
        tx_two       = 1'b0;

        case (state_q)
            StIdle: begin
                if (rx_d_vld_i) begin
                    state_d = cmd_state(rx_p_data_i[7:0]);
                end
            end
            StWrAddr: begin
                if (rx_d_vld_i) begin
                    addr_d  = rx_p_data_i[AddrW-1:0];
                    state_d = StWrData;
                end
            end
            StWrData: begin
                if (rx_d_vld_i) begin
                    rf_wr_en_d   = 1'b1;
                    rf_addr_d    = addr_q;
                    rf_wr_data_d = rx_p_data_i;
                    state_d      = StIdle;
                end
            end
            StRdAddr: begin
                if (rx_d_vld_i) begin
                    rf_rd_en_d = 1'b1;
                    rf_addr_d  = rx_p_data_i[AddrW-1:0];
                    cnt_d      = '0;
                    state_d    = StRdWait;
                end
            end
            StRdWait: begin
                err_d = rx_d_vld_i;
                // A valid arriving on the final wait cycle still completes the read.
                if (rf_rd_data_vld_i) begin
                    result_d = {rf_rd_data_i, {DataW{1'b0}}};
                    tx_start = 1'b1;
                    state_d  = StTx1;
                end else if (wait_last) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StOpa: begin
                if (rx_d_vld_i) begin
                    rf_wr_en_d   = 1'b1;
                    rf_addr_d    = AddrW'(OpaAddr);
                    rf_wr_data_d = rx_p_data_i;
                    state_d      = StOpb;
                end
            end
            StOpb: begin
                if (rx_d_vld_i) begin
                    rf_wr_en_d   = 1'b1;
                    rf_addr_d    = AddrW'(OpbAddr);
                    rf_wr_data_d = rx_p_data_i;
                    state_d      = StFun;
                end
            end
            StFun: begin
                if (rx_d_vld_i) begin
                    alu_fun_d = rx_p_data_i[FunW-1:0];
                    alu_en_d  = 1'b1;
                    gate_d    = 1'b1;
                    cnt_d     = '0;
                    state_d   = StAluWait;
                end
            end
            StAluWait: begin
                err_d = rx_d_vld_i;
                if (alu_out_vld_i) begin
                    result_d = alu_out_i;
                    alu_en_d = 1'b0;
                    gate_d   = 1'b0;
                    tx_start = 1'b1;
                    tx_two   = 1'b1;
                    state_d  = StTx0;
                end else if (wait_last) begin
                    alu_en_d = 1'b0;
                    gate_d   = 1'b0;
                    err_d    = 1'b1;
                    state_d  = StIdle;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            // The byte-level TX phases live in the sequencer; here StTx0/StTx1
            // only mark which send was started and wait for its completion.
            StTx0, StTx1: begin
                err_d = rx_d_vld_i;
                if (tx_done) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge ref_clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            addr_q       <= '0;
            result_q     <= '0;
            cnt_q        <= '0;
            rf_addr_q    <= '0;
            rf_wr_en_q   <= 1'b0;
            rf_rd_en_q   <= 1'b0;
            rf_wr_data_q <= '0;
            alu_en_q     <= 1'b0;
            alu_fun_q    <= '0;
            gate_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            result_q     <= result_d;
            cnt_q        <= cnt_d;
            rf_addr_q    <= rf_addr_d;
            rf_wr_en_q   <= rf_wr_en_d;
            rf_rd_en_q   <= rf_rd_en_d;
            rf_wr_data_q <= rf_wr_data_d;
            alu_en_q     <= alu_en_d;
            alu_fun_q    <= alu_fun_d;
            gate_q       <= gate_d;
            err_q        <= err_d;
        end
    end

    sys_ctrl_tx_seq #(
        .DataW (DataW)
    ) u_tx_seq (
        .clk_i       (ref_clk_i),
        .rst_i       (rst_i),
        .start_i     (tx_start),
        .two_byte_i  (tx_two),
        .byte0_i     (result_q[DataW-1:0]),
        .byte1_i     (result_q[2*DataW-1:DataW]),
        .tx_busy_i   (tx_busy_i),
        .tx_p_data_o (tx_p_data_o),
        .tx_d_vld_o  (tx_d_vld_o),
        .done_o      (tx_done)
    );

    assign rf_addr_o     = rf_addr_q;
    assign rf_wr_en_o    = rf_wr_en_q;
    assign rf_rd_en_o    = rf_rd_en_q;
    assign rf_wr_data_o  = rf_wr_data_q;
    assign alu_en_o      = alu_en_q;
    assign alu_fun_o     = alu_fun_q;
    assign clk_gate_en_o = gate_q;
    assign err_pulse_o   = err_q;

endmodule

// File: tb/tb_sys_ctrl_fsm.sv
// Directed, table-driven bench for sys_ctrl_fsm with behavioural RF, ALU and
// UART TX responders.
module tb_sys_ctrl_fsm;

    logic        clk;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_vld;
    logic [7:0]  rf_rd_data;
    logic        rf_vld;
    logic [15:0] alu_out;
    logic        alu_vld;
    logic        tx_busy;
    logic [3:0]  rf_addr;
    logic        rf_wr_en;
    logic        rf_rd_en;
    logic [7:0]  rf_wr_data;
    logic        alu_en;
    logic [3:0]  alu_fun;
    logic        clk_gate_en;
    logic [7:0]  tx_p_data;
    logic        tx_d_vld;
    logic        err_pulse;

    sys_ctrl_fsm dut (
        .ref_clk_i        (clk),
        .rst_i            (rst),
        .rx_p_data_i      (rx_data),
        .rx_d_vld_i       (rx_vld),
        .rf_rd_data_i     (rf_rd_data),
        .rf_rd_data_vld_i (rf_vld),
        .alu_out_i        (alu_out),
        .alu_out_vld_i    (alu_vld),
        .tx_busy_i        (tx_busy),
        .rf_addr_o        (rf_addr),
        .rf_wr_en_o       (rf_wr_en),
        .rf_rd_en_o       (rf_rd_en),
        .rf_wr_data_o     (rf_wr_data),
        .alu_en_o         (alu_en),
        .alu_fun_o        (alu_fun),
        .clk_gate_en_o    (clk_gate_en),
        .tx_p_data_o      (tx_p_data),
        .tx_d_vld_o       (tx_d_vld),
        .err_pulse_o      (err_pulse)
    );

    typedef struct {
        int              nb;
        logic [3:0][7:0] bytes;
        logic [7:0]      rf_d;
        int              rf_lat;
        logic [15:0]     alu_d;
        int              alu_lat;
        int              n_wr;
        logic [1:0][11:0] wr;
        int              n_rd;
        logic [3:0]      rd_addr;
        int              n_tx;
        logic [1:0][7:0] tx;
        int              n_err;
        bit              fun_chk;
        logic [3:0]      fun;
    } vec_t;

    localparam int NVec = 11;
    vec_t vecs[NVec];

    int          n_cmp;
    int          n_bad;
    int          cyc;
    int          rf_lat;
    int          alu_lat;
    int          busy_len;
    logic [7:0]  rf_resp;
    logic [15:0] alu_resp;

    logic [11:0] wr_q[$];
    logic [7:0]  tx_q[$];
    int          rd_n;
    int          err_n;
    int          burst_n;
    int          rd_cyc;
    int          err_cyc;
    logic [3:0]  rd_addr_seen;
    logic [3:0]  fun_seen;
    logic        vld_prev;
    logic        alu_en_prev;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // Event monitor sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (rf_wr_en) wr_q.push_back({rf_addr, rf_wr_data});
            if (rf_rd_en) begin
                rd_n++;
                rd_addr_seen = rf_addr;
                rd_cyc = cyc;
            end
            if (err_pulse) begin
                err_n++;
                err_cyc = cyc;
            end
            if (tx_d_vld && !vld_prev) burst_n++;
            if (alu_en && !alu_en_prev) fun_seen = alu_fun;
        end
        vld_prev    = tx_d_vld;
        alu_en_prev = alu_en;
    end

    // UART transmitter: takes a requested byte and stays busy for busy_len cycles.
    initial begin
        tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_d_vld && !tx_busy && !rst) begin
                tx_q.push_back(tx_p_data);
                @(posedge clk);
                #1 tx_busy = 1'b1;
                repeat (busy_len) @(posedge clk);
                #1 tx_busy = 1'b0;
            end
        end
    end

    // Register file read port; a latency of 0 means it never answers.
    initial begin
        rf_vld = 1'b0;
        rf_rd_data = '0;
        forever begin
            @(negedge clk);
            if (rf_rd_en && rf_lat > 0) begin
                repeat (rf_lat) @(posedge clk);
                #1 rf_rd_data = rf_resp;
                rf_vld = 1'b1;
                @(posedge clk);
                #1 rf_vld = 1'b0;
            end
        end
    end

    initial begin
        alu_vld = 1'b0;
        alu_out = '0;
        forever begin
            @(negedge clk);
            if (alu_en && alu_lat > 0) begin
                repeat (alu_lat) @(posedge clk);
                #1 alu_out = alu_resp;
                alu_vld = 1'b1;
                @(posedge clk);
                #1 alu_vld = 1'b0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int nb, input logic [31:0] bytes, input logic [7:0] rf_d,
                                input int rf_l, input logic [15:0] alu_d, input int alu_l,
                                input int n_wr, input logic [23:0] wr, input int n_rd,
                                input logic [3:0] rd_addr, input int n_tx, input logic [15:0] tx,
                                input int n_err, input bit fun_chk, input logic [3:0] fun);
        vec_t v;
        v.nb = nb;       v.bytes = bytes;   v.rf_d = rf_d;   v.rf_lat = rf_l;
        v.alu_d = alu_d; v.alu_lat = alu_l; v.n_wr = n_wr;   v.wr = wr;
        v.n_rd = n_rd;   v.rd_addr = rd_addr; v.n_tx = n_tx; v.tx = tx;
        v.n_err = n_err; v.fun_chk = fun_chk; v.fun = fun;
        return v;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk);
        #1 rx_data = b;
        rx_vld = 1'b1;
        @(posedge clk);
        #1 rx_vld = 1'b0;
    endtask

    task automatic clear_obs();
        wr_q.delete();
        tx_q.delete();
        rd_n = 0;
        err_n = 0;
        burst_n = 0;
        fun_seen = '0;
    endtask

    function automatic logic [31:0] out_bus();
        return 32'({rf_addr, rf_wr_en, rf_rd_en, rf_wr_data, alu_en, alu_fun, clk_gate_en,
                    tx_p_data, tx_d_vld, err_pulse});
    endfunction

    task automatic run_vec(input vec_t v, input int idx);
        clear_obs();
        rf_lat = v.rf_lat;
        rf_resp = v.rf_d;
        alu_lat = v.alu_lat;
        alu_resp = v.alu_d;
        for (int i = 0; i < v.nb; i++) send_byte(v.bytes[i]);
        repeat (60) @(posedge clk);
        #1;
        chk($sformatf("v%0d wr_count", idx), 32'(wr_q.size()), 32'(v.n_wr));
        for (int i = 0; i < v.n_wr && i < wr_q.size(); i++)
            chk($sformatf("v%0d wr%0d addr_data", idx, i), 32'(wr_q[i]), 32'(v.wr[i]));
        chk($sformatf("v%0d rd_count", idx), 32'(rd_n), 32'(v.n_rd));
        if (v.n_rd > 0) chk($sformatf("v%0d rd_addr", idx), 32'(rd_addr_seen), 32'(v.rd_addr));
        chk($sformatf("v%0d tx_count", idx), 32'(tx_q.size()), 32'(v.n_tx));
        chk($sformatf("v%0d tx_bursts", idx), 32'(burst_n), 32'(v.n_tx));
        for (int i = 0; i < v.n_tx && i < tx_q.size(); i++)
            chk($sformatf("v%0d tx%0d", idx, i), 32'(tx_q[i]), 32'(v.tx[i]));
        chk($sformatf("v%0d err_count", idx), 32'(err_n), 32'(v.n_err));
        if (v.fun_chk) chk($sformatf("v%0d alu_fun", idx), 32'(fun_seen), 32'(v.fun));
        chk($sformatf("v%0d enables_idle", idx), 32'({alu_en, clk_gate_en}), 32'(0));
    endtask

    initial begin
        rst = 1'b1;
        rx_data = '0;
        rx_vld = 1'b0;
        rf_lat = 0;
        alu_lat = 0;
        rf_resp = '0;
        alu_resp = '0;
        busy_len = 3;
        n_cmp = 0;
        n_bad = 0;
        cyc = 0;
        vld_prev = 1'b0;
        alu_en_prev = 1'b0;
        rd_cyc = 0;
        err_cyc = 0;
        rd_addr_seen = '0;
        clear_obs();

        vecs[0]  = mk(3, 32'h003C05AA, 8'h00, 0,  16'h0000, 0, 1, 24'h00053C, 0, 4'h0,
                      0, 16'h0000, 0, 0, 4'h0);
        vecs[1]  = mk(2, 32'h000005BB, 8'h3C, 2,  16'h0000, 0, 0, 24'h000000, 1, 4'h5,
                      1, 16'h003C, 0, 0, 4'h0);
        vecs[2]  = mk(4, 32'h00140ACC, 8'h00, 0,  16'h001E, 3, 2, 24'h11400A, 0, 4'h0,
                      2, 16'h001E, 0, 1, 4'h0);
        vecs[3]  = mk(2, 32'h00000ADD, 8'h00, 0,  16'h0005, 2, 0, 24'h000000, 0, 4'h0,
                      2, 16'h0005, 0, 1, 4'hA);
        vecs[4]  = mk(2, 32'h00000BDD, 8'h00, 0,  16'h0014, 4, 0, 24'h000000, 0, 4'h0,
                      2, 16'h0014, 0, 1, 4'hB);
        vecs[5]  = mk(1, 32'h00000055, 8'h00, 0,  16'h0000, 0, 0, 24'h000000, 0, 4'h0,
                      0, 16'h0000, 0, 0, 4'h0);
        vecs[6]  = mk(2, 32'h000007BB, 8'h5A, 14, 16'h0000, 0, 0, 24'h000000, 1, 4'h7,
                      1, 16'h005A, 0, 0, 4'h0);
        vecs[7]  = mk(2, 32'h000003DD, 8'h00, 0,  16'h0000, 0, 0, 24'h000000, 0, 4'h0,
                      0, 16'h0000, 1, 1, 4'h3);
        vecs[8]  = mk(2, 32'h000002BB, 8'h00, 0,  16'h0000, 0, 0, 24'h000000, 1, 4'h2,
                      0, 16'h0000, 1, 0, 4'h0);
        vecs[9]  = mk(3, 32'h00811FAA, 8'h00, 0,  16'h0000, 0, 1, 24'h000F81, 0, 4'h0,
                      0, 16'h0000, 0, 0, 4'h0);
        vecs[10] = mk(4, 32'h0201FFCC, 8'h00, 0,  16'h1A2B, 1, 2, 24'h1010FF, 0, 4'h0,
                      2, 16'h1A2B, 0, 1, 4'h2);

        repeat (3) @(posedge clk);
        #1;
        chk("reset outputs", out_bus(), 32'(0));
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("idle after reset", out_bus(), 32'(0));

        for (int i = 0; i < NVec; i++) run_vec(vecs[i], i);

        // Timeout latency: ERR follows the read strobe by exactly WAIT_MAX cycles.
        run_vec(vecs[8], 8);
        chk("timeout latency", 32'(err_cyc - rd_cyc), 32'(15));
        run_vec(vecs[0], 0);

        // Byte arriving while the second result byte is being serialised.
        clear_obs();
        busy_len = 10;
        alu_lat = 2;
        alu_resp = 16'h1234;
        send_byte(8'hDD);
        send_byte(8'h0A);
        for (int k = 0; k < 300 && tx_q.size() < 2; k++) @(posedge clk);
        chk("drop tx reached", 32'(tx_q.size()), 32'(2));
        repeat (3) @(posedge clk);
        #1 rx_data = 8'h77;
        rx_vld = 1'b1;
        @(posedge clk);
        #1 rx_vld = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        chk("drop err_count", 32'(err_n), 32'(1));
        chk("drop tx_count", 32'(tx_q.size()), 32'(2));
        chk("drop tx_bursts", 32'(burst_n), 32'(2));
        if (tx_q.size() == 2) begin
            chk("drop tx0", 32'(tx_q[0]), 32'(8'h34));
            chk("drop tx1", 32'(tx_q[1]), 32'(8'h12));
        end
        busy_len = 3;
        run_vec(vecs[0], 0);

        // Reset in the middle of an ALU command, then a full command afterwards.
        clear_obs();
        alu_lat = 0;
        send_byte(8'hCC);
        send_byte(8'h0A);
        @(posedge clk);
        #1 rst = 1'b1;
        #2;
        chk("mid-reset outputs", out_bus(), 32'(0));
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("post-reset outputs", out_bus(), 32'(0));
        run_vec(vecs[2], 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule
